// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Circular byte buffer feeding a UART transmitter. Words are
//               enqueued at up to one per clock and launched one at a time as
//               a single-cycle P_DATA/Data_Valid strobe, paced by the
//               transmitter's busy flag (with a timeout in case busy never
//               rises after a launch).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK           in   clock, rising edge
//   RST           in   synchronous active-low reset
//   WR_DATA       in   word to enqueue
//   WR_EN         in   enqueue request
//   FULL          out  occupancy == DEPTH (registered)
//   EMPTY         out  occupancy == 0 (registered)
//   COUNT         out  occupancy, clog2(DEPTH)+1 bits (registered)
//   OVERFLOW      out  one-cycle pulse after a rejected write
//   TX_P_DATA     out  word to the transmitter, held until the next launch
//   TX_DATA_VALID out  one-cycle launch strobe
//   TX_BUSY       in   transmitter busy, synchronous to CLK
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         WR_DATA,
    input  logic                     WR_EN,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_DATA_VALID,
    input  logic                     TX_BUSY
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;
    localparam int c_tmr_w  = $clog2(BUSY_TIMEOUT);

    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_busy = 2'd1;
    localparam logic [1:0] c_st_wait_done = 2'd2;

    // Storage and pointers
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;

    // Launch sequencer
    logic [1:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic [WIDTH-1:0]   r_tx_data;
    logic               r_tx_valid;

    logic [1:0]         w_state_nxt;
    logic [c_tmr_w-1:0] w_timer_nxt;
    logic               w_launch;
    logic               w_wr_accept;
    logic [c_ptr_w-1:0] w_wr_ptr_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    // FULL is the registered pre-edge flag, so a write coinciding with a pop
    // while full is still rejected.
    assign w_wr_accept  = WR_EN & ~r_full;
    assign w_wr_ptr_nxt = r_wr_ptr + c_ptr_w'(w_wr_accept);
    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_launch);

    // Next-state / launch decision
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_launch    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!r_empty && !TX_BUSY) begin
                    w_launch    = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_wait_busy;
                end
            end
            c_st_wait_busy: begin
                // Busy wins over the timeout when both happen on the same edge.
                if (TX_BUSY) begin
                    w_state_nxt = c_st_wait_done;
                end else if (r_timer == c_tmr_last) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            c_st_wait_done: begin
                if (!TX_BUSY) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= c_st_idle;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Array write; contents are not reset, pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (RST && w_wr_accept) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= WR_DATA;
        end
    end

    // Pointers, flags and transmitter outputs. Flags are computed from the
    // post-edge pointers so they are registered yet current.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full     <= (w_wr_ptr_nxt[c_addr_w-1:0] == w_rd_ptr_nxt[c_addr_w-1:0]) &&
                          (w_wr_ptr_nxt[c_addr_w] != w_rd_ptr_nxt[c_addr_w]);
            r_overflow <= WR_EN & r_full;
            r_tx_valid <= w_launch;
            if (w_launch) begin
                r_tx_data <= r_mem[r_rd_ptr[c_addr_w-1:0]];
            end
        end
    end

    assign FULL          = r_full;
    assign EMPTY         = r_empty;
    assign COUNT         = r_count;
    assign OVERFLOW      = r_overflow;
    assign TX_P_DATA     = r_tx_data;
    assign TX_DATA_VALID = r_tx_valid;

endmodule
`default_nettype wire
